rtc_scan_decoder: RTL and testbench



---
 rtl/rtc_scan_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_rtc_scan_decoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_scan_decoder.sv
// Receive-side decoder for a multiplexed 7-segment scan: filters each dwell, decodes glyphs to BCD, rebuilds frames.
// Optional idle timeout enabled by defining RTC_SCAN_TIMEOUT_EN.
module rtc_scan_decoder #(
    parameter int NDIG        = 6,
    parameter int STABLE_CNT  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                intclk,
    input  logic                i_reset_n,
    input  logic [7:0]          i_sel,
    input  logic [7:0]          i_seg,
    output logic [4*NDIG-1:0]   o_bcd,
    output logic [NDIG-1:0]     o_dp,
    output logic [4*NDIG-1:0]   o_frame_bcd,
    output logic                o_frame_done,
    output logic                o_err_seq,
    output logic                o_err_glyph
`ifdef RTC_SCAN_TIMEOUT_EN
    ,
    output logic                o_timeout
`endif
);

    typedef enum logic {SYNC, RUN} state_t;

    state_t              state_q, state_d;
    logic [2:0]          expect_q, expect_d;
    logic [15:0]         samp_q, samp_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic [NDIG-1:0]     dp_q, dp_d;
    logic [4*NDIG-1:0]   fbcd_q, fbcd_d;
    logic                done_q, done_d;
    logic                eseq_q, eseq_d;
    logic                eglyph_q, eglyph_d;

    logic                changed;
    logic                accept;
    logic [3:0]          sel_hits;
    logic [2:0]          sel_idx;
    logic                sel_blank;
    logic                sel_valid;
    logic [6:0]          lit;
    logic [3:0]          glyph;
    logic                glyph_bad;
    logic                store;

`ifdef RTC_SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic                to_q, to_d;
    logic                accept_valid;
`endif

    // Stability filter: a dwell is accepted only on the cycle its run length hits STABLE_CNT.
    always_comb begin
        samp_d  = {i_sel, i_seg};
        changed = (samp_d != samp_q);
        cnt_d   = cnt_q;
        if (changed) begin
            cnt_d = 4'd1;
        end else if (cnt_q != 4'(STABLE_CNT)) begin
            cnt_d = cnt_q + 4'd1;
        end
        accept = (cnt_d == 4'(STABLE_CNT)) && (changed || (cnt_q != 4'(STABLE_CNT)));
    end

    always_comb begin
        sel_hits = 4'd0;
        sel_idx  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!i_sel[k]) begin
                sel_hits = sel_hits + 4'd1;
                sel_idx  = 3'(k);
            end
        end
        sel_blank = (i_sel == 8'hFF);
        sel_valid = (sel_hits == 4'd1) && (int'(sel_idx) < NDIG);
    end

    always_comb begin
        lit       = ~i_seg[6:0];
        glyph_bad = 1'b0;
        case (lit)
            7'b0111111: glyph = 4'd0;
            7'b0000110: glyph = 4'd1;
            7'b1011011: glyph = 4'd2;
            7'b1001111: glyph = 4'd3;
            7'b1100110: glyph = 4'd4;
            7'b1101101: glyph = 4'd5;
            7'b1111101: glyph = 4'd6;
            7'b0000111: glyph = 4'd7;
            7'b1111111: glyph = 4'd8;
            7'b1101111: glyph = 4'd9;
            7'b0000000: glyph = 4'hF;
            default: begin
                glyph     = 4'hE;
                glyph_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        bcd_d    = bcd_q;
        dp_d     = dp_q;
        fbcd_d   = fbcd_q;
        done_d   = 1'b0;
        eseq_d   = 1'b0;
        eglyph_d = 1'b0;
        store    = 1'b0;

        if (accept && !sel_blank) begin
            if (!sel_valid) begin
                eseq_d  = 1'b1;
                state_d = SYNC;
            end else if (state_q == SYNC) begin
                store = (sel_idx == 3'd0);
            end else if (sel_idx == expect_q) begin
                store = 1'b1;
            end else if (sel_idx == 3'd0) begin
                // Out-of-order digit 0 restarts the frame rather than dropping to SYNC.
                store  = 1'b1;
                eseq_d = 1'b1;
            end else begin
                eseq_d  = 1'b1;
                state_d = SYNC;
            end
        end

        if (store) begin
            bcd_d[4*int'(sel_idx) +: 4] = glyph;
            dp_d[sel_idx]               = ~i_seg[7];
            eglyph_d                    = glyph_bad;
            state_d                     = RUN;
            if (int'(sel_idx) == NDIG - 1) begin
                done_d   = 1'b1;
                fbcd_d   = bcd_d;
                expect_d = 3'd0;
            end else begin
                expect_d = sel_idx + 3'd1;
            end
        end

`ifdef RTC_SCAN_TIMEOUT_EN
        accept_valid = accept && sel_valid;
        to_cnt_d     = to_cnt_q;
        to_d         = to_q;
        if (accept_valid) begin
            to_cnt_d = '0;
            to_d     = 1'b0;
        end else if (to_cnt_q != TW'(TIMEOUT_CYC)) begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_d == TW'(TIMEOUT_CYC)) begin
                to_d    = 1'b1;
                state_d = SYNC;
                bcd_d   = {NDIG{4'hF}};
            end
        end
`endif
    end

    always_ff @(posedge intclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= SYNC;
            expect_q <= 3'd0;
            samp_q   <= 16'hFFFF;
            cnt_q    <= 4'd0;
            bcd_q    <= {NDIG{4'hF}};
            dp_q     <= '0;
            fbcd_q   <= {NDIG{4'hF}};
            done_q   <= 1'b0;
            eseq_q   <= 1'b0;
            eglyph_q <= 1'b0;
`ifdef RTC_SCAN_TIMEOUT_EN
            to_cnt_q <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            samp_q   <= samp_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            dp_q     <= dp_d;
            fbcd_q   <= fbcd_d;
            done_q   <= done_d;
            eseq_q   <= eseq_d;
            eglyph_q <= eglyph_d;
`ifdef RTC_SCAN_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            to_q     <= to_d;
`endif
        end
    end

    assign o_bcd        = bcd_q;
    assign o_dp         = dp_q;
    assign o_frame_bcd  = fbcd_q;
    assign o_frame_done = done_q;
    assign o_err_seq    = eseq_q;
    assign o_err_glyph  = eglyph_q;
`ifdef RTC_SCAN_TIMEOUT_EN
    assign o_timeout    = to_q;
`endif

endmodule

// File: tb/tb_rtc_scan_decoder.sv
// Bench for rtc_scan_decoder: directed scan scenarios plus randomized dwells against a behavioural frame model.
module tb_rtc_scan_decoder;
    localparam int NDIG        = 6;
    localparam int STABLE_CNT  = 2;
    localparam int TIMEOUT_CYC = 64;

    logic                intclk = 1'b0;
    logic                i_reset_n = 1'b1;
    logic [7:0]          i_sel = 8'hFF;
    logic [7:0]          i_seg = 8'hFF;
    logic [4*NDIG-1:0]   o_bcd;
    logic [NDIG-1:0]     o_dp;
    logic [4*NDIG-1:0]   o_frame_bcd;
    logic                o_frame_done;
    logic                o_err_seq;
    logic                o_err_glyph;
`ifdef RTC_SCAN_TIMEOUT_EN
    logic                o_timeout;
`endif

    rtc_scan_decoder #(
        .NDIG(NDIG), .STABLE_CNT(STABLE_CNT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .intclk(intclk),
        .i_reset_n(i_reset_n),
        .i_sel(i_sel),
        .i_seg(i_seg),
        .o_bcd(o_bcd),
        .o_dp(o_dp),
        .o_frame_bcd(o_frame_bcd),
        .o_frame_done(o_frame_done),
        .o_err_seq(o_err_seq),
        .o_err_glyph(o_err_glyph)
`ifdef RTC_SCAN_TIMEOUT_EN
        ,
        .o_timeout(o_timeout)
`endif
    );

    always #5 intclk = ~intclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fd_cnt = 0, es_cnt = 0, eg_cnt = 0, done_cyc = -1;

    logic [6:0] gl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    // Behavioural model state
    logic [15:0]       prev;
    int                run_len;
    int                m_bcd [NDIG];
    int                m_fbcd [NDIG];
    bit                m_dp [NDIG];
    bit                m_done, m_es, m_eg, m_to, in_run;
    int                next_dig, idle;
    logic [4*NDIG-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] enc(input int g, input bit dp);
        return {~dp, ~gl[g]};
    endfunction

    function automatic int sel_digit(input logic [7:0] s);
        int n = 0;
        int idx = -1;
        for (int k = 0; k < 8; k++) begin
            if (!s[k]) begin
                n++;
                idx = k;
            end
        end
        if (n == 1 && idx < NDIG) return idx;
        return -1;
    endfunction

    function automatic int glyph_val(input logic [7:0] seg);
        logic [6:0] m;
        m = ~seg[6:0];
        for (int g = 0; g < 10; g++) if (m == gl[g]) return g;
        if (m == 7'd0) return 15;
        return 14;
    endfunction

    function automatic logic [4*NDIG-1:0] pack_bcd(input int a [NDIG]);
        logic [4*NDIG-1:0] v;
        for (int k = 0; k < NDIG; k++) v[4*k +: 4] = 4'(a[k]);
        return v;
    endfunction

    function automatic logic [NDIG-1:0] pack_dp();
        logic [NDIG-1:0] v;
        for (int k = 0; k < NDIG; k++) v[k] = m_dp[k];
        return v;
    endfunction

    // Model: run-length of identical samples, frame sequencing with plain integers.
    initial begin
        forever begin
            @(posedge intclk or negedge i_reset_n);
            if (!i_reset_n) begin
                prev = 16'hFFFF; run_len = 0;
                for (int k = 0; k < NDIG; k++) begin
                    m_bcd[k] = 15; m_fbcd[k] = 15; m_dp[k] = 1'b0;
                end
                m_done = 0; m_es = 0; m_eg = 0; m_to = 0; in_run = 0;
                next_dig = 0; idle = 0;
                exp_q.delete();
            end else begin
                int d, g;
                bit take, valid_acc;
                run_len = ({i_sel, i_seg} == prev) ? run_len + 1 : 1;
                prev = {i_sel, i_seg};
                m_done = 0; m_es = 0; m_eg = 0; valid_acc = 0;
                if (run_len == STABLE_CNT && i_sel != 8'hFF) begin
                    d = sel_digit(i_sel);
                    take = 0;
                    if (d < 0) begin
                        m_es = 1; in_run = 0;
                    end else begin
                        valid_acc = 1;
                        if (!in_run) take = (d == 0);
                        else if (d == next_dig) take = 1;
                        else if (d == 0) begin take = 1; m_es = 1; end
                        else begin m_es = 1; in_run = 0; end
                    end
                    if (take) begin
                        g = glyph_val(i_seg);
                        m_bcd[d] = g; m_dp[d] = !i_seg[7]; m_eg = (g == 14);
                        in_run = 1; next_dig = d + 1;
                        if (d == NDIG - 1) begin
                            m_done = 1; m_fbcd = m_bcd; next_dig = 0;
                            exp_q.push_back(pack_bcd(m_bcd));
                        end
                    end
                end
`ifdef RTC_SCAN_TIMEOUT_EN
                if (valid_acc) begin
                    idle = 0; m_to = 0;
                end else if (idle < TIMEOUT_CYC) begin
                    idle++;
                    if (idle == TIMEOUT_CYC) begin
                        m_to = 1; in_run = 0;
                        for (int k = 0; k < NDIG; k++) m_bcd[k] = 15;
                    end
                end
`endif
            end
        end
    end

    always @(posedge intclk) cyc <= cyc + 1;

    // Compare process: DUT against model every cycle, frame snapshots against the expected queue.
    always @(negedge intclk) begin
        chk("bcd", o_bcd, pack_bcd(m_bcd));
        chk("dp", o_dp, pack_dp());
        chk("frame_bcd", o_frame_bcd, pack_bcd(m_fbcd));
        chk("frame_done", o_frame_done, m_done);
        chk("err_seq", o_err_seq, m_es);
        chk("err_glyph", o_err_glyph, m_eg);
`ifdef RTC_SCAN_TIMEOUT_EN
        chk("timeout", o_timeout, m_to);
`endif
        if (o_frame_done) begin
            if (exp_q.size() > 0) chk("frame_sb", o_frame_bcd, exp_q.pop_front());
            else chk("frame_sb_empty", o_frame_done, 1'b0);
        end
    end

    always @(negedge intclk) begin
        if (o_frame_done) begin fd_cnt++; done_cyc = cyc; end
        if (o_err_seq) es_cnt++;
        if (o_err_glyph) eg_cnt++;
    end

    task automatic drive(input logic [7:0] sel, input logic [7:0] seg, input int n);
        i_sel = sel; i_seg = seg;
        repeat (n) @(negedge intclk);
    endtask

    task automatic scan_digit(input int d, input logic [7:0] seg);
        drive(~(8'h01 << d), seg, 4);
        drive(8'hFF, 8'hFF, 1);
    endtask

    task automatic zero_counts();
        fd_cnt = 0; es_cnt = 0; eg_cnt = 0;
    endtask

    initial begin
        int appear_cyc, r, seq;
        logic [7:0] s, g;
        #1 i_reset_n = 1'b0;
        repeat (2) @(negedge intclk);
        chk("reset_bcd", o_bcd, 24'hFFFFFF);
        chk("reset_fbcd", o_frame_bcd, 24'hFFFFFF);
        chk("reset_dp", o_dp, 6'd0);
        i_reset_n = 1'b1;
        drive(8'hFF, 8'hFF, 2);

        // Full frame, glyphs 1..6
        zero_counts();
        appear_cyc = 0;
        for (int d = 0; d < NDIG; d++) begin
            if (d == NDIG - 1) appear_cyc = cyc;
            scan_digit(d, enc(d + 1, 1'b0));
        end
        chk("f1_done_count", fd_cnt, 1);
        chk("f1_latency", done_cyc - appear_cyc, 2);
        chk("f1_frame_bcd", o_frame_bcd, 24'h654321);
        chk("f1_model_fbcd", pack_bcd(m_fbcd), 24'h654321);

        // Digit 2 blank with dp lit
        scan_digit(0, enc(0, 1'b0));
        scan_digit(1, enc(0, 1'b0));
        scan_digit(2, 8'h7F);
        chk("dp_blank_bcd", o_bcd[11:8], 4'hF);
        chk("dp_blank_dp", o_dp[2], 1'b1);

        // 0,1,3 -> sequence error, then 4 ignored in SYNC, then a clean frame
        scan_digit(0, enc(0, 1'b0));
        scan_digit(1, enc(0, 1'b0));
        zero_counts();
        scan_digit(3, enc(8, 1'b0));
        chk("seq_err_count", es_cnt, 1);
        scan_digit(4, enc(9, 1'b0));
        chk("sync_ignore_err", es_cnt, 1);
        chk("sync_ignore_bcd", o_bcd[19:16], 4'h5);
        zero_counts();
        for (int d = 0; d < NDIG; d++) scan_digit(d, enc(9 - d, 1'b0));
        chk("f2_done_count", fd_cnt, 1);
        chk("f2_frame_bcd", o_frame_bcd, 24'h456789);
        chk("f2_no_err", es_cnt, 0);

        // Single-cycle glitch inside a digit-0 dwell
        zero_counts();
        drive(8'hFE, enc(3, 1'b0), 1);
        drive(8'hFB, enc(3, 1'b0), 1);
        drive(8'hFE, enc(3, 1'b0), 3);
        drive(8'hFF, 8'hFF, 1);
        chk("glitch_no_err", es_cnt, 0);
        chk("glitch_d0", o_bcd[3:0], 4'h3);
        chk("glitch_d2_kept", o_bcd[11:8], 4'h7);

        // Two selects low, then an unknown glyph
        zero_counts();
        drive(8'hFC, enc(1, 1'b0), 3);
        drive(8'hFF, 8'hFF, 1);
        chk("multi_sel_err", es_cnt, 1);
        drive(8'hFE, 8'hAA, 3);
        drive(8'hFF, 8'hFF, 1);
        chk("glyph_err_count", eg_cnt, 1);
        chk("glyph_err_bcd", o_bcd[3:0], 4'hE);

        // Reset in the middle of a frame
        scan_digit(1, enc(2, 1'b1));
        scan_digit(2, enc(2, 1'b0));
        scan_digit(3, enc(2, 1'b0));
        #2 i_reset_n = 1'b0;
        #1;
        chk("midrst_bcd", o_bcd, 24'hFFFFFF);
        chk("midrst_fbcd", o_frame_bcd, 24'hFFFFFF);
        chk("midrst_dp", o_dp, 6'd0);
        chk("midrst_done", o_frame_done, 1'b0);
        @(negedge intclk);
        i_reset_n = 1'b1;
        zero_counts();
        for (int d = 0; d < NDIG; d++) scan_digit(d, enc(d, 1'b0));
        chk("f3_done_count", fd_cnt, 1);
        chk("f3_frame_bcd", o_frame_bcd, 24'h543210);

`ifdef RTC_SCAN_TIMEOUT_EN
        drive(8'hFF, 8'hFF, TIMEOUT_CYC + 4);
        chk("to_set", o_timeout, 1'b1);
        chk("to_bcd", o_bcd, 24'hFFFFFF);
        scan_digit(0, enc(4, 1'b0));
        chk("to_clear", o_timeout, 1'b0);
`endif

        // Randomized dwells, checked cycle by cycle against the model
        seq = 0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                s = ~(8'h01 << seq);
                seq = (seq + 1) % NDIG;
            end else if (r < 80) begin
                s = ~(8'h01 << $urandom_range(0, 7));
            end else if (r < 90) begin
                s = 8'($urandom);
            end else begin
                s = 8'hFF;
            end
            r = $urandom_range(0, 99);
            if (r < 70) g = enc($urandom_range(0, 9), 1'($urandom_range(0, 1)));
            else if (r < 85) g = {1'($urandom_range(0, 1)), 7'h7F};
            else g = 8'($urandom);
            drive(s, g, $urandom_range(1, 5));
            if ($urandom_range(0, 3) == 0) drive(8'hFF, 8'hFF, 1);
        end
        drive(8'hFF, 8'hFF, 3);
        chk("frames_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
